dmem_io_responder: RTL

DMEM_IO_RESPONDER -- requirements
Module: dmem_io_responder

---
 rtl/dm_pkg.sv | 36 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/dmem_io_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings, address map and FSM states for the data-memory responder
package dm_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   localparam logic [31:0] ADDR_LED = 32'h0000_0400;
   localparam logic [31:0] ADDR_SW  = 32'h0000_0404;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } dm_state_t;

   // Selects the addressed byte/half of a word and extends it per the load type.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ctrl);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (ctrl)
         CTRL_B:  return {{24{b[7]}}, b};
         CTRL_BU: return {24'h0, b};
         CTRL_H:  return {{16{h[15]}}, h};
         CTRL_HU: return {16'h0, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - fixed-latency data memory with LED and switch registers
module dmem_io_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_ctrl,
   input  logic [7:0]  switches,
   output logic [7:0]  leds,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   logic [31:0] mem [DEPTH_WORDS];

   dm_state_t   state;
   logic [3:0]  wait_cnt;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  ctrl_q;
   logic [7:0]  sw_sync;

   sync_2ff #(.WIDTH(8)) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (switches),
      .q     (sw_sync)
   );

   // With LATENCY=1 the access completes on the accept edge, so decode reads the live request in IDLE.
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [2:0]  cur_ctrl;
   logic        accept, enter_resp;
   logic        is_ram, is_led, is_sw, misaligned, bad_ctrl, acc_err;
   logic [AW-1:0] word_idx;
   logic [3:0]  be;
   logic [31:0] wr_word;
   logic [31:0] load_data;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      cur_we     = (state == ST_IDLE) ? req_we    : we_q;
      cur_addr   = (state == ST_IDLE) ? req_addr  : addr_q;
      cur_wdata  = (state == ST_IDLE) ? req_wdata : wdata_q;
      cur_ctrl   = (state == ST_IDLE) ? req_ctrl  : ctrl_q;
      enter_resp = ((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                   ((state == ST_WAIT) && (wait_cnt == 4'd0));

      is_ram     = (cur_addr < RAM_BYTES);
      is_led     = (cur_addr == ADDR_LED);
      is_sw      = (cur_addr == ADDR_SW);
      misaligned = (((cur_ctrl == CTRL_H) || (cur_ctrl == CTRL_HU)) && cur_addr[0]) ||
                   ((cur_ctrl == CTRL_W) && (cur_addr[1:0] != 2'b00));
      bad_ctrl   = cur_we ? !((cur_ctrl == CTRL_B) || (cur_ctrl == CTRL_H) || (cur_ctrl == CTRL_W))
                          : ((cur_ctrl == 3'b011) || (cur_ctrl == 3'b110) || (cur_ctrl == 3'b111));
      acc_err    = misaligned || bad_ctrl || !(is_ram || is_led || is_sw) || (cur_we && is_sw);

      word_idx   = cur_addr[AW+1:2];
      case (cur_ctrl)
         CTRL_B: begin
            be      = 4'b0001 << cur_addr[1:0];
            wr_word = {4{cur_wdata[7:0]}};
         end
         CTRL_H: begin
            be      = cur_addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{cur_wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wr_word = cur_wdata;
         end
      endcase

      if (is_led)
         load_data = {24'h0, leds};
      else if (is_sw)
         load_data = {24'h0, sw_sync};
      else
         load_data = load_extend(mem[word_idx], cur_addr[1:0], cur_ctrl);
   end

   // RAM is deliberately left unreset; gating on rst_n drops writes from an abandoned request.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && cur_we && is_ram && !acc_err) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k])
               mem[word_idx][8*k +: 8] <= wr_word[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         ctrl_q     <= 3'b000;
         leds       <= 8'h00;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || cur_we) ? 32'h0 : load_data;
            if (cur_we && is_led && !acc_err)
               leds <= cur_wdata[7:0];
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q     <= req_we;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  ctrl_q   <= req_ctrl;
                  wait_cnt <= WAIT_LOAD;
                  state    <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0)
                  state <= ST_RESP;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
